// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter for the shared data-memory port. Tenures are
// burst-bounded, and read returns are tagged through a fixed-latency pipeline.
module dmem_arbiter #(
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [2:0]  op0,
  input  logic [2:0]  op1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [2:0]  mem_op,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_dout,
  output logic [1:0]  owner
);

  // State encoding doubles as the owner debug field.
  typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;

  localparam logic [8:0] BURST_MAX = 9'(MAX_BURST);
  localparam logic [7:0] BURST_SAT = 8'(MAX_BURST);

  state_t      state, state_nxt;
  logic        last_owner, last_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [8:0]  cnt_inc;
  logic        sel1, xfer, cur_we;

  assign sel1    = (state == OWN1);
  assign gnt0    = (state == OWN0) & req0;
  assign gnt1    = sel1 & req1;
  assign xfer    = gnt0 | gnt1;
  assign cur_we  = sel1 ? we1 : we0;
  assign mem_we  = xfer & cur_we;
  assign mem_re  = xfer & ~cur_we;
  assign owner   = state;
  assign cnt_inc = {1'b0, cnt} + 9'd1;

  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_op   = '0;
    case (state)
      OWN0: begin
        mem_addr = addr0;
        mem_din  = wdata0;
        mem_op   = op0;
      end
      OWN1: begin
        mem_addr = addr1;
        mem_din  = wdata1;
        mem_op   = op1;
      end
      default: ;
    endcase
  end

  // A tenure ends on release, or on the burst limit only while the peer waits;
  // otherwise the count saturates and the owner keeps the port.
  always_comb begin
    state_nxt = state;
    last_nxt  = last_owner;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req0 && req1) state_nxt = last_owner ? OWN0 : OWN1;
        else if (req0)    state_nxt = OWN0;
        else if (req1)    state_nxt = OWN1;
      end
      OWN0: begin
        if (!req0 || (req1 && cnt_inc >= BURST_MAX)) begin
          state_nxt = req1 ? OWN1 : IDLE;
          last_nxt  = 1'b0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = (cnt_inc >= BURST_MAX) ? BURST_SAT : cnt_inc[7:0];
        end
      end
      OWN1: begin
        if (!req1 || (req0 && cnt_inc >= BURST_MAX)) begin
          state_nxt = req0 ? OWN0 : IDLE;
          last_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = (cnt_inc >= BURST_MAX) ? BURST_SAT : cnt_inc[7:0];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_nxt;
      cnt        <= cnt_nxt;
    end
  end

  // Read-return pipeline: stage 1 is loaded in the transfer cycle, the output
  // register adds the final edge so rvalid lands RD_LAT+1 edges later.
  logic [RD_LAT:1] vld_pipe, tag_pipe;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata    <= '0;
    end else begin
      vld_pipe <= RD_LAT'({vld_pipe, mem_re});
      tag_pipe <= RD_LAT'({tag_pipe, sel1});
      rvalid0  <= vld_pipe[RD_LAT] & ~tag_pipe[RD_LAT];
      rvalid1  <= vld_pipe[RD_LAT] & tag_pipe[RD_LAT];
      rdata    <= mem_dout;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: instances with RD_LAT 1 and 3 share stimulus;
// read returns are popped from a per-instance queue of expected {cycle, tag, data}.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [2:0]  op0 = 3'd2, op1 = 3'd5;

  logic        gnt0 [2], gnt1 [2], rvalid0 [2], rvalid1 [2], mem_we [2], mem_re [2];
  logic [31:0] rdata [2], mem_addr [2], mem_din [2], mem_dout [2];
  logic [2:0]  mem_op [2];
  logic [1:0]  owner [2];

  dmem_arbiter #(.RD_LAT(1), .MAX_BURST(8)) dut_a (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .op0(op0), .op1(op1),
    .gnt0(gnt0[0]), .gnt1(gnt1[0]), .rvalid0(rvalid0[0]), .rvalid1(rvalid1[0]),
    .rdata(rdata[0]), .mem_addr(mem_addr[0]), .mem_din(mem_din[0]), .mem_op(mem_op[0]),
    .mem_we(mem_we[0]), .mem_re(mem_re[0]), .mem_dout(mem_dout[0]), .owner(owner[0]));

  dmem_arbiter #(.RD_LAT(3), .MAX_BURST(8)) dut_b (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .op0(op0), .op1(op1),
    .gnt0(gnt0[1]), .gnt1(gnt1[1]), .rvalid0(rvalid0[1]), .rvalid1(rvalid1[1]),
    .rdata(rdata[1]), .mem_addr(mem_addr[1]), .mem_din(mem_din[1]), .mem_op(mem_op[1]),
    .mem_we(mem_we[1]), .mem_re(mem_re[1]), .mem_dout(mem_dout[1]), .owner(owner[1]));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5EED_1234;
  endfunction

  // Memory model: read data appears exactly RD_LAT cycles after mem_re.
  logic [3:0]  v_hist [2] = '{4'b0, 4'b0};
  logic [31:0] a_hist [2][4];
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      v_hist[i] <= {v_hist[i][2:0], mem_re[i]};
      a_hist[i][0] <= mem_addr[i];
      for (int j = 1; j < 4; j++) a_hist[i][j] <= a_hist[i][j-1];
    end
  end
  assign mem_dout[0] = v_hist[0][0] ? mdata(a_hist[0][0]) : 32'hDEAD_BEEF;
  assign mem_dout[1] = v_hist[1][2] ? mdata(a_hist[1][2]) : 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] cyc;
    logic        tag;
    logic [31:0] data;
  } exp_t;
  exp_t sbq [2][$];

  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic stp();
    @(posedge clock);
    #1;
  endtask

  // Called in the read-transfer cycle; returns land RD_LAT+1 edges later.
  task automatic push_rd(input logic tag, input logic [31:0] addr);
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      e.cyc  = 32'(cyc + (i == 0 ? 1 : 3) + 1);
      e.tag  = tag;
      e.data = mdata(addr);
      sbq[i].push_back(e);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [1:0] own, input logic g1,
                         input logic g0, input logic we, input logic re,
                         input logic [31:0] addr);
    logic [2:0] op;
    op = (own == 2'b01) ? op0 : (own == 2'b10) ? op1 : 3'd0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_ctl%0d", tag, i),
          32'({mem_op[i], owner[i], gnt1[i], gnt0[i], mem_we[i], mem_re[i]}),
          32'({op, own, g1, g0, we, re}));
      chk($sformatf("%s_addr%0d", tag, i), mem_addr[i], addr);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (sbq[i].size() > 0 && int'(sbq[i][0].cyc) < cyc) begin
        chk($sformatf("rv_missing%0d", i), 32'(cyc), sbq[i][0].cyc);
        void'(sbq[i].pop_front());
      end
      if (rvalid0[i] || rvalid1[i]) begin
        if (sbq[i].size() == 0) begin
          chk($sformatf("rv_spurious%0d", i), 32'({rvalid1[i], rvalid0[i]}), 32'd0);
        end else begin
          e = sbq[i].pop_front();
          chk($sformatf("rv_cyc%0d", i), 32'(cyc), e.cyc);
          chk($sformatf("rv_tag%0d", i), 32'({rvalid1[i], rvalid0[i]}),
              e.tag ? 32'd2 : 32'd1);
          chk($sformatf("rv_data%0d", i), rdata[i], e.data);
        end
      end
    end
  end

  initial begin
    logic t0;
    // Reset held with both masters requesting: everything stays quiet.
    #1 reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    addr0 = 32'h200; addr1 = 32'h300; wdata0 = 32'h1; wdata1 = 32'h2;
    repeat (2) stp();
    #1;
    chk_bus("rst", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_rv%0d", i), 32'({rvalid1[i], rvalid0[i]}), 32'd0);
      chk($sformatf("rst_rdata%0d", i), rdata[i], 32'd0);
    end

    // Tie from reset: master 0 first, then 8/8 alternation with no dead cycle.
    reset = 1'b1;
    #1;
    chk_bus("tie_idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int k = 1; k <= 32; k++) begin
      stp();
      #1;
      t0 = (((k - 1) / 8) % 2) == 0;
      chk_bus($sformatf("tie_k%0d", k), t0 ? 2'b01 : 2'b10, ~t0, t0, 1'b1, 1'b0,
              t0 ? 32'h200 : 32'h300);
    end
    stp();
    req0 = 1'b0; req1 = 1'b0;
    #1;
    chk_bus("tie_drop", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200);
    stp();
    #1;
    chk_bus("tie_idle2", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Single master read.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100;
    stp();
    #1;
    chk_bus("rd1", 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100);
    push_rd(1'b0, 32'h100);
    stp();
    req0 = 1'b0;
    #1;
    chk_bus("rd1_rel", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100);
    repeat (5) stp();

    // Early release: master 1 writes three words, then master 0 takes over.
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'hA0; wdata1 = 32'h11;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
    for (int k = 0; k < 3; k++) begin
      stp();
      addr1 = 32'hA0 + 32'(4 * k);
      wdata1 = 32'h11 * 32'(k + 1);
      #1;
      chk_bus($sformatf("wr%0d", k), 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA0 + 32'(4 * k));
      for (int i = 0; i < 2; i++)
        chk($sformatf("wr_din%0d_%0d", k, i), mem_din[i], 32'h11 * 32'(k + 1));
    end
    stp();
    req1 = 1'b0;
    #1;
    chk_bus("wr_rel", 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA8);
    stp();
    #1;
    chk_bus("sw0", 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 32'h40);
    push_rd(1'b0, 32'h40);
    stp();
    req0 = 1'b0;
    #1;
    chk_bus("sw0_rel", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40);
    repeat (5) stp();

    // Burst-limit switch lands master 0 reads and a master 1 read back to back.
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h500;
    stp();
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h8;
    #1;
    chk_bus("bw1", 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 32'h500);
    for (int k = 2; k <= 6; k++) begin
      stp();
      #1;
      chk_bus($sformatf("bw%0d", k), 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 32'h500);
    end
    stp();
    we0 = 1'b0; addr0 = 32'h0;
    #1;
    chk_bus("br0", 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    push_rd(1'b0, 32'h0);
    stp();
    addr0 = 32'h4;
    #1;
    chk_bus("br4", 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4);
    push_rd(1'b0, 32'h4);
    stp();
    req0 = 1'b0;
    #1;
    chk_bus("br8", 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8);
    push_rd(1'b1, 32'h8);
    stp();
    req1 = 1'b0;
    #1;
    chk_bus("b_rel", 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8);
    repeat (6) stp();

    // Saturation: lone master keeps the port; a late peer request still cuts in.
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h600;
    for (int k = 1; k <= 20; k++) begin
      stp();
      #1;
      chk_bus($sformatf("sat%0d", k), 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 32'h600);
    end
    stp();
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h680;
    #1;
    chk_bus("sat_last", 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 32'h600);
    stp();
    #1;
    chk_bus("sat_sw", 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 32'h680);
    stp();
    req0 = 1'b0; req1 = 1'b0;
    #1;
    chk_bus("sat_rel", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 32'h680);
    stp();

    // Reset with reads in flight: quiet at once, returns discarded.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h700;
    stp();
    #1;
    chk_bus("rr0", 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 32'h700);
    stp();
    addr0 = 32'h704;
    #1;
    chk_bus("rr1", 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 32'h704);
    stp();
    reset = 1'b0;
    #1;
    chk_bus("rst_mid", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_mid_rv%0d", i), 32'({rvalid1[i], rvalid0[i]}), 32'd0);
      chk($sformatf("rst_mid_rdata%0d", i), rdata[i], 32'd0);
    end
    stp();
    reset = 1'b1; addr0 = 32'h710;
    #1;
    chk_bus("post_rst_idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    stp();
    #1;
    chk_bus("post_rst_gnt", 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 32'h710);
    push_rd(1'b0, 32'h710);
    stp();
    req0 = 1'b0;
    repeat (8) stp();

    chk("sb_empty", 32'(sbq[0].size() + sbq[1].size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
